// File: rtl/check_x_lanes_if.sv
// rtl/check_x_lanes_if.sv - monitored bus, controls and status of the X-lane checker
interface check_x_lanes_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int LANE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 32
);
  localparam int NUM_LANES = BUS_WIDTH / LANE_WIDTH;
  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                           check_en;
  logic [NUM_LANES-1:0]           select;
  logic [BUS_WIDTH-1:0]           bus;
  logic                           clear;
  logic                           armed;
  logic                           halted;
  logic                           err_pulse;
  logic [NUM_LANES-1:0]           err_lanes;
  logic [NUM_LANES-1:0]           sticky_lanes;
  logic                           first_valid;
  logic [LANE_IDX_W-1:0]          first_lane;
  logic [TS_WIDTH-1:0]            first_time;
  logic [NUM_LANES*CNT_WIDTH-1:0] lane_counts;
  logic [CNT_WIDTH-1:0]           total_count;

  modport master (
    output check_en, select, bus, clear,
    input  armed, halted, err_pulse, err_lanes, sticky_lanes,
           first_valid, first_lane, first_time, lane_counts, total_count
  );

  modport slave (
    input  check_en, select, bus, clear,
    output armed, halted, err_pulse, err_lanes, sticky_lanes,
           first_valid, first_lane, first_time, lane_counts, total_count
  );
endinterface

// File: rtl/check_x_lanes.sv
// rtl/check_x_lanes.sv - per-lane X/Z detector with sticky status, counters and first-error capture
module check_x_lanes #(
  parameter int BUS_WIDTH      = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int STARTUP_CYCLES = 400,
  parameter int CNT_WIDTH      = 16,
  parameter int TS_WIDTH       = 32,
  parameter int HALT_ON_ERR    = 0
) (
  input logic            clock,
  input logic            reset,
  check_x_lanes_if.slave mon
);
  localparam int NUM_LANES = BUS_WIDTH / LANE_WIDTH;
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;
  localparam logic [31:0] SU_LAST = (STARTUP_CYCLES > 0) ? 32'(STARTUP_CYCLES - 1) : 32'd0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]                     state_q, state_d;
  logic [31:0]                    su_cnt_q, su_cnt_d;
  logic [TS_WIDTH-1:0]            ts_q, ts_d;
  logic                           err_pulse_q, err_pulse_d;
  logic [NUM_LANES-1:0]           err_lanes_q, err_lanes_d;
  logic [NUM_LANES-1:0]           sticky_q, sticky_d;
  logic                           first_valid_q, first_valid_d;
  logic [LW-1:0]                  first_lane_q, first_lane_d;
  logic [TS_WIDTH-1:0]            first_time_q, first_time_d;
  logic [NUM_LANES*CNT_WIDTH-1:0] counts_q, counts_d;
  logic [CNT_WIDTH-1:0]           total_q, total_d;

  logic [NUM_LANES-1:0] lane_err;
  logic [LW-1:0]        low_lane;
  logic                 check_ok;
  logic [TS_WIDTH-1:0]  ts_eff;

  // A clear while HALTED re-arms on this same edge, so that edge is checked too.
  always_comb begin
    check_ok = mon.check_en && ((state_q == ST_ARMED) || (state_q == ST_HALTED && mon.clear));
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_err[i] = check_ok && mon.select[i] && $isunknown(^mon.bus[i*LANE_WIDTH +: LANE_WIDTH]);
    end
    low_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_err[i]) low_lane = LW'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    su_cnt_d      = su_cnt_q;
    ts_d          = ts_q;
    ts_eff        = ts_q;
    err_pulse_d   = |lane_err;
    err_lanes_d   = lane_err;
    sticky_d      = sticky_q;
    first_valid_d = first_valid_q;
    first_lane_d  = first_lane_q;
    first_time_d  = first_time_q;
    counts_d      = counts_q;
    total_d       = total_q;

    case (state_q)
      ST_STARTUP: begin
        if (su_cnt_q == SU_LAST) begin
          state_d = ST_ARMED;
          ts_d    = '0;
        end else begin
          su_cnt_d = su_cnt_q + 32'd1;
        end
      end
      ST_ARMED: ts_d = ts_q + 1'b1;
      ST_HALTED: begin
        if (mon.clear) begin
          state_d = ST_ARMED;
          ts_d    = '0;
          ts_eff  = '0;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    // Clear first, then record any error seen on the same edge.
    if (mon.clear) begin
      sticky_d      = '0;
      counts_d      = '0;
      total_d       = '0;
      first_valid_d = 1'b0;
      first_lane_d  = '0;
      first_time_d  = '0;
    end

    if (|lane_err) begin
      sticky_d = sticky_d | lane_err;
      if (total_d != CNT_MAX) total_d = total_d + 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_err[i] && counts_d[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)
          counts_d[i*CNT_WIDTH +: CNT_WIDTH] = counts_d[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
      if (!first_valid_d) begin
        first_valid_d = 1'b1;
        first_lane_d  = low_lane;
        first_time_d  = ts_eff;
      end
      if (HALT_ON_ERR != 0) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_STARTUP;
      su_cnt_q      <= '0;
      ts_q          <= '0;
      err_pulse_q   <= 1'b0;
      err_lanes_q   <= '0;
      sticky_q      <= '0;
      first_valid_q <= 1'b0;
      first_lane_q  <= '0;
      first_time_q  <= '0;
      counts_q      <= '0;
      total_q       <= '0;
    end else begin
      state_q       <= state_d;
      su_cnt_q      <= su_cnt_d;
      ts_q          <= ts_d;
      err_pulse_q   <= err_pulse_d;
      err_lanes_q   <= err_lanes_d;
      sticky_q      <= sticky_d;
      first_valid_q <= first_valid_d;
      first_lane_q  <= first_lane_d;
      first_time_q  <= first_time_d;
      counts_q      <= counts_d;
      total_q       <= total_d;
    end
  end

  assign mon.armed        = (state_q == ST_ARMED);
  assign mon.halted       = (state_q == ST_HALTED);
  assign mon.err_pulse    = err_pulse_q;
  assign mon.err_lanes    = err_lanes_q;
  assign mon.sticky_lanes = sticky_q;
  assign mon.first_valid  = first_valid_q;
  assign mon.first_lane   = first_lane_q;
  assign mon.first_time   = first_time_q;
  assign mon.lane_counts  = counts_q;
  assign mon.total_count  = total_q;
endmodule
